// File: rtl/pma_ser_pkg.sv
// pma_ser_pkg: shared defaults and state encoding for the PMA serializer.
package pma_ser_pkg;
  localparam int DEF_WIDTH = 10;
  localparam logic DEF_IDLE_LEVEL = 1'b0;
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;
endpackage

// File: rtl/word_clk_div.sv
// word_clk_div: divides the bit clock by WIDTH into Bit_Rate_10 and decodes
// the capture (cnt WIDTH/2-1 -> WIDTH/2) and boundary (cnt WIDTH-1 -> 0) edges.
module word_clk_div #(
  parameter int WIDTH = 10
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_bit_rate_10,
  output logic o_cap_edge,
  output logic o_bnd_edge
);
  localparam int CW = $clog2(WIDTH);
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_bit_rate_10;
  assign o_bnd_edge    = r_cnt == CW'(WIDTH - 1);
  assign o_cap_edge    = r_cnt == CW'(WIDTH / 2 - 1);
  assign w_cnt_nxt     = o_bnd_edge ? '0 : r_cnt + CW'(1);
  assign o_bit_rate_10 = r_bit_rate_10;
  // Reset to WIDTH-1 so the first edge lands on cnt 0 and raises the word clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt         <= CW'(WIDTH - 1);
      r_bit_rate_10 <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_bit_rate_10 <= w_cnt_nxt < CW'(WIDTH / 2);
    end
  end
endmodule

// File: rtl/pma_serializer_10b.sv
// pma_serializer_10b: captures a code group mid-word and shifts it out one bit
// per bit clock, holding the line at IDLE_LEVEL when the PMA is not enabled.
module pma_serializer_10b
  import pma_ser_pkg::*;
#(
  parameter int   WIDTH      = DEF_WIDTH,
  parameter bit   LSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = DEF_IDLE_LEVEL
) (
  input  logic             Bit_Rate_CLK,
  input  logic             Rst,
  input  logic [WIDTH-1:0] Data_10,
  input  logic             enable_PMA,
  output logic             Bit_Rate_10,
  output logic             TX_Out,
  output logic             TX_Idle,
  output logic             Load_Strobe
);
  logic             w_cap_edge;
  logic             w_bnd_edge;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_vld;
  logic [WIDTH-1:0] r_shreg;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_src;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic             w_load;
  logic             w_tx_nxt;
  logic             w_idle_nxt;
  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
    return LSB_FIRST ? {1'b0, v[WIDTH-1:1]} : {v[WIDTH-2:0], 1'b0};
  endfunction
  function automatic logic head(input logic [WIDTH-1:0] v);
    return LSB_FIRST ? v[0] : v[WIDTH-1];
  endfunction
  word_clk_div #(.WIDTH(WIDTH)) u_div (
    .i_clk        (Bit_Rate_CLK),
    .i_rst_n      (Rst),
    .o_bit_rate_10(Bit_Rate_10),
    .o_cap_edge   (w_cap_edge),
    .o_bnd_edge   (w_bnd_edge)
  );
  always_ff @(posedge Bit_Rate_CLK or negedge Rst) begin
    if (!Rst) begin
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
    end else if (w_cap_edge) begin
      r_hold     <= Data_10;
      r_hold_vld <= enable_PMA;
    end
  end
  always_ff @(posedge Bit_Rate_CLK or negedge Rst) begin
    if (!Rst) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  // At the boundary bit 0 goes straight from the hold register to the line,
  // so the shift register is loaded already advanced by one position.
  always_comb begin
    w_load      = w_bnd_edge & r_hold_vld;
    w_state_nxt = w_bnd_edge ? (r_hold_vld ? ACTIVE : IDLE) : r_state;
    w_src       = w_bnd_edge ? r_hold : r_shreg;
    w_tx_nxt    = (w_state_nxt == ACTIVE) ? head(w_src) : IDLE_LEVEL;
    w_idle_nxt  = w_state_nxt == IDLE;
    w_shreg_nxt = w_load ? shift_out(r_hold) : (r_state == ACTIVE ? shift_out(r_shreg) : r_shreg);
  end
  always_ff @(posedge Bit_Rate_CLK or negedge Rst) begin
    if (!Rst) begin
      r_shreg     <= '0;
      TX_Out      <= IDLE_LEVEL;
      TX_Idle     <= 1'b1;
      Load_Strobe <= 1'b0;
    end else begin
      r_shreg     <= w_shreg_nxt;
      TX_Out      <= w_tx_nxt;
      TX_Idle     <= w_idle_nxt;
      Load_Strobe <= w_load;
    end
  end
endmodule

// File: tb/tb_pma_serializer_10b.sv
// tb_pma_serializer_10b: directed and random words checked against a word-slot
// model (edge count -> cnt, capture snapshot, word in flight).
module tb_pma_serializer_10b;
  localparam int W = 10;
  localparam logic [W-1:0] K285P = 10'b0011111010;
  localparam logic [W-1:0] K285N = 10'b1100000101;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] data = '0;
  logic en = 1'b0;
  logic br10, tx, tx_idle, ld;
  int checks = 0;
  int errors = 0;
  int e = 0;
  bit in_rst = 1'b1;
  logic [W-1:0] cap_d = '0;
  bit cap_v = 1'b0;
  logic [W-1:0] cur_d = '0;
  bit cur_v = 1'b0;
  pma_serializer_10b dut (
    .Bit_Rate_CLK(clk),
    .Rst         (rst_n),
    .Data_10     (data),
    .enable_PMA  (en),
    .Bit_Rate_10 (br10),
    .TX_Out      (tx),
    .TX_Idle     (tx_idle),
    .Load_Strobe (ld)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s edge %0d: got %b expected %b", tag, e, got, exp);
    end
  endtask
  task automatic check_all();
    int k;
    if (in_rst || e == 0) begin
      chk("br10_rst", br10, 1'b0);
      chk("tx_rst", tx, 1'b0);
      chk("idle_rst", tx_idle, 1'b1);
      chk("ld_rst", ld, 1'b0);
    end else begin
      k = (e - 1) % W;
      chk("br10", br10, k < W / 2);
      chk("tx", tx, cur_v ? cur_d[k] : 1'b0);
      chk("idle", tx_idle, !cur_v);
      chk("ld", ld, cur_v && k == 0);
    end
  endtask
  // One bit clock: drive inputs, advance the model at the edge, check mid-cycle.
  task automatic step(input logic [W-1:0] d, input logic v);
    int k;
    data = d;
    en = v;
    @(posedge clk);
    e++;
    k = (e - 1) % W;
    if (k == W / 2) begin
      cap_d = d;
      cap_v = v;
    end
    if (k == 0) begin
      cur_d = cap_d;
      cur_v = cap_v;
    end
    @(negedge clk);
    check_all();
  endtask
  task automatic word(input logic [W-1:0] d, input logic v);
    for (int j = 0; j < W; j++) step(d, v);
  endtask
  initial begin
    logic [W-1:0] r;
    repeat (3) begin
      @(negedge clk);
      check_all();
    end
    rst_n = 1'b1;
    in_rst = 1'b0;
    for (int i = 0; i < 3; i++) word(W'($urandom), 1'b0);
    word(K285P, 1'b1);
    word(K285P, 1'b0);
    word(K285P, 1'b0);
    for (int i = 0; i < 4; i++) word(i[0] ? K285N : K285P, 1'b1);
    for (int j = 0; j < W; j++) step(K285N, j < 3);
    word(K285P, 1'b0);
    word(K285P, 1'b0);
    r = W'($urandom);
    for (int j = 0; j < W; j++) step(j < 8 ? r : ~r, 1'b1);
    word(W'($urandom), 1'b1);
    for (int i = 0; i < 20; i++) word(W'($urandom), ($urandom % 4) != 0);
    for (int j = 0; j < 7; j++) step(r, 1'b1);
    rst_n = 1'b0;
    in_rst = 1'b1;
    #1;
    check_all();
    repeat (4) begin
      @(negedge clk);
      check_all();
    end
    rst_n = 1'b1;
    in_rst = 1'b0;
    e = 0;
    cap_v = 1'b0;
    cur_v = 1'b0;
    for (int i = 0; i < 4; i++) word(W'($urandom), 1'b1);
    word(W'($urandom), 1'b0);
    word(W'($urandom), 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
